// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: FSM state encodings
// and the helper that sizes the shared dwell counter.
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Counter must hold max(show, blank) - 1; never narrower than one bit.
  function automatic int cnt_width(input int show_cyc, input int blank_cyc);
    int longest;
    int w;
    longest = (show_cyc > blank_cyc) ? show_cyc : blank_cyc;
    w       = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Dwell counter for the scan FSM: counts up from zero, flags when it reaches
// the terminal value, and is cleared synchronously by the owner.
module cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed display scan controller: alternates an all-off dead-time
// with a lit slot for each digit, driving the mux select and digit enables.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SEL_W     = 2,
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIGITS-1:0] blank_mask,
  output logic [SEL_W-1:0]  sel,
  output logic [DIGITS-1:0] digit_en_n,
  output logic              tick,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = cnt_width(SHOW_CYC, BLANK_CYC);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             cnt_clr;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_term;

  assign cnt_term = (state_q == ST_SHOW) ? CNT_W'(SHOW_CYC - 1) : CNT_W'(BLANK_CYC - 1);

  cycle_counter #(
    .W (CNT_W)
  ) u_cycle_counter (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (cnt_clr),
    .term_i (cnt_term),
    .done_o (cnt_done)
  );

  // enable low wins over every transition and forces a fresh start at digit 0.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    cnt_clr = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          sel_d   = '0;
          cnt_clr = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_done) begin
            state_d = ST_SHOW;
            cnt_clr = 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_done) begin
            state_d = ST_BLANK;
            cnt_clr = 1'b1;
            tick_d  = 1'b1;
            sel_d   = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sel_d   = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  // Mask only gates the enable; slot timing and sel are untouched.
  always_comb begin
    digit_en_n = '1;
    if (state_q == ST_SHOW) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_q == SEL_W'(i) && !blank_mask[i]) digit_en_n[i] = 1'b0;
      end
    end
  end

  assign sel       = sel_q;
  assign tick      = tick_q;
  assign state_dbg = state_q;

endmodule
